hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and stall sequencer for the five-stage pipeline. It watches the instruction in decode (stage 2) and the producers in EX (stage 3) and MEM (stage 4). It freezes PC and IF/ID and injects ID/EX bubbles for the cycles needed until the decode-stage operand forwarding can supply correct CBZ, B.cond and ALU operands. It also issues the one-cycle IF/ID flush for taken branches resolved in decode.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- id_valid  in  1  decode slot holds a real instruction
- id_is_cbz  in  1  decode instruction is CBZ; tests id_rt
- id_is_bcond  in  1  decode instruction is B.cond; reads flags
- id_uses_rn, id_uses_rm  in  1  decode reads Rn / Rm through the ALU path
- id_rn, id_rm, id_rt  in  5  decode source register numbers
- id_br_taken  in  1  branch resolved taken in decode
- ex_wr_en, ex_is_load, ex_sets_flags  in  1  EX-stage producer control
- ex_rd  in  5  EX-stage destination
- mem_wr_en, mem_is_load  in  1  MEM-stage producer control
- mem_rd  in  5  MEM-stage destination
- ext_stall  in  1  data-memory busy; freezes the whole pipeline
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID register write enable
- idex_bubble  out  1  load NOP into ID/EX
- ifid_flush  out  1  clear IF/ID on next edge
- stall_cycles  out  32  count of stall cycles (perf)
- flush_count  out  32  count of flushes (perf)

## Operation
- Register 31 (XZR) never matches any producer; all compares against 5'd31 are suppressed.
- Hazard depth is evaluated only in state RUN with id_valid=1:
  - Depth 2: CBZ with id_rt == ex_rd, ex_wr_en=1, ex_is_load=1.
  - Depth 1, any one of:
    - CBZ with id_rt == ex_rd, ex_wr_en=1, ex_is_load=0.
    - CBZ with id_rt == mem_rd, mem_wr_en=1, mem_is_load=1.
    - B.cond with ex_sets_flags=1.
    - ALU load-use: id_rn or id_rm is used, equals ex_rd, ex_wr_en=1, ex_is_load=1.
  - Otherwise depth 0.
  - When more than one condition holds, the larger depth wins.
- States: RUN, STALL2, STALL1.
  - RUN → STALL1 when the depth is 1.
  - RUN → STALL2 when the depth is 2.
  - STALL2 → STALL1 unconditionally.
  - STALL1 → RUN unconditionally.
- Outputs, when ext_stall=0:
  - Stalling means (RUN and depth>0) or STALL2, i.e. every stall cycle except the final one.
  - While stalling: pc_we=0, ifid_we=0, idex_bubble=1.
  - STALL1 is the final (release) cycle. It does no re-detection: pc_we=1, ifid_we=1, idex_bubble=0.
  - In RUN with depth 0: pc_we=1, ifid_we=1, idex_bubble=0.
- ifid_flush=1 when id_br_taken=1 in a non-stalling cycle, meaning RUN with depth 0, or STALL1.
  - A branch seen during a stalling cycle is ignored; it is re-resolved once forwarding is valid.
- ext_stall=1 overrides everything:
  - pc_we=0, ifid_we=0, idex_bubble=0, ifid_flush=0.
  - The FSM holds its state and the counters hold their values.

## Timing
- Detection is combinational. Outputs are valid in the same cycle as their inputs.
- State is registered on the rising edge of clk.
- Stall latency from first detection: depth 1 costs 1 bubble, depth 2 costs 2 bubbles.
- While reset=0 (sampled on the clock edge):
  - The state becomes RUN and the counters clear to 0.
  - Outputs are forced to pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=1.
- A reset arriving mid-stall abandons the stall. The next cycle after release starts in RUN.
- Counters:
  - stall_cycles increments on each cycle where idex_bubble=1 and reset=1.
  - flush_count increments on each cycle where ifid_flush=1 and reset=1.
  - Both wrap modulo 2^32.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles and flush_count are implemented as described.
- HAZARD_PERF_EN undefined: no counter registers are built. Both ports remain present and are tied to 32'd0.

## Structure
- Shared package pipe_pkg holds:
  - the state enum hz_state_t {RUN, STALL2, STALL1};
  - the constant XZR = 5'd31;
  - the stall-depth constants LOAD_CBZ_DEPTH = 2 and ALU_CBZ_DEPTH = 1.
- Sub-module reg_match does the 5-bit equality compare with XZR suppression and a write-enable qualifier. It is instantiated once per source/producer pair.

## Test plan
- CBZ X3 in ID while LDUR X3 is in EX → 2 cycles with pc_we=0 and idex_bubble=1, then STALL1 release, then RUN. stall_cycles=2.
- CBZ X5 in ID while ADD X5 is in EX → exactly 1 bubble (the RUN cycle with depth 1), then STALL1 release with pc_we=1. Same case with ex_rd=31 → 0 bubbles.
- ADD X1,X2,X7 in ID while LDUR X7 is in EX → 1 bubble. LDUR X7 in MEM instead → no stall.
- CBZ taken, no hazard → ifid_flush=1 for one cycle and flush_count=1. The same CBZ behind an LDUR dependency → no flush during the 2 stall cycles, then the flush comes in the STALL1 cycle.
- ext_stall=1 for 3 cycles while in STALL2 → all outputs hold off, state stays STALL2, counters are unchanged. The sequence resumes afterwards.
- reset=0 during STALL2 → on the next edge the state is RUN and the counters are 0. After release, a hazard-free instruction sees pc_we=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall sequencer: FSM state
// encoding, the zero-register number and the stall depths per hazard class.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL2 = 2'd1,
        STALL1 = 2'd2
    } hz_state_t;

    // X31 reads as zero and is never a real producer.
    localparam logic [4:0] XZR = 5'd31;

    localparam int unsigned LOAD_CBZ_DEPTH = 2;
    localparam int unsigned ALU_CBZ_DEPTH  = 1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/EX/MEM hazard inputs and the stall/flush controls plus perf counters.
// master: the pipeline side driving the stage info; slave: hazard_ctrl.
interface hazard_ctrl_if;

    logic        id_valid;
    logic        id_is_cbz;
    logic        id_is_bcond;
    logic        id_uses_rn;
    logic        id_uses_rm;
    logic [4:0]  id_rn;
    logic [4:0]  id_rm;
    logic [4:0]  id_rt;
    logic        id_br_taken;
    logic        ex_wr_en;
    logic        ex_is_load;
    logic        ex_sets_flags;
    logic [4:0]  ex_rd;
    logic        mem_wr_en;
    logic        mem_is_load;
    logic [4:0]  mem_rd;
    logic        ext_stall;
    logic        pc_we;
    logic        ifid_we;
    logic        idex_bubble;
    logic        ifid_flush;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output id_valid, id_is_cbz, id_is_bcond, id_uses_rn, id_uses_rm,
        output id_rn, id_rm, id_rt, id_br_taken,
        output ex_wr_en, ex_is_load, ex_sets_flags, ex_rd,
        output mem_wr_en, mem_is_load, mem_rd, ext_stall,
        input  pc_we, ifid_we, idex_bubble, ifid_flush, stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_is_cbz, id_is_bcond, id_uses_rn, id_uses_rm,
        input  id_rn, id_rm, id_rt, id_br_taken,
        input  ex_wr_en, ex_is_load, ex_sets_flags, ex_rd,
        input  mem_wr_en, mem_is_load, mem_rd, ext_stall,
        output pc_we, ifid_we, idex_bubble, ifid_flush, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_reg_match.sv
// Source/producer register compare: true when the producer writes the source
// register and that register is not XZR.
module reg_match
    import pipe_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] dst_i,
    input  logic       wr_en_i,
    output logic       match_o
);

    // Compare only live writes; XZR never matches.
    always_comb begin
        match_o = wr_en_i && (src_i == dst_i) && (src_i != XZR) && (dst_i != XZR);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer. Detects decode-stage dependencies on EX/MEM
// producers, freezes PC and IF/ID while injecting ID/EX bubbles, and issues the
// IF/ID flush for taken decode-resolved branches.
// Optional perf counters are built when HAZARD_PERF_EN is defined; otherwise
// stall_cycles and flush_count read as zero.
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    logic       cbz_ex_match;
    logic       cbz_mem_match;
    logic       rn_ex_match;
    logic       rm_ex_match;
    logic [1:0] depth;
    logic       stalling;

    hz_state_t  state_q, state_d;

    logic       pc_we;
    logic       ifid_we;
    logic       idex_bubble;
    logic       ifid_flush;

    reg_match u_cbz_ex (
        .src_i   (bus.id_rt),
        .dst_i   (bus.ex_rd),
        .wr_en_i (bus.ex_wr_en),
        .match_o (cbz_ex_match)
    );

    reg_match u_cbz_mem (
        .src_i   (bus.id_rt),
        .dst_i   (bus.mem_rd),
        .wr_en_i (bus.mem_wr_en),
        .match_o (cbz_mem_match)
    );

    reg_match u_rn_ex (
        .src_i   (bus.id_rn),
        .dst_i   (bus.ex_rd),
        .wr_en_i (bus.ex_wr_en),
        .match_o (rn_ex_match)
    );

    reg_match u_rm_ex (
        .src_i   (bus.id_rm),
        .dst_i   (bus.ex_rd),
        .wr_en_i (bus.ex_wr_en),
        .match_o (rm_ex_match)
    );

    // Stall depth needed before decode forwarding is valid; larger depth wins.
    always_comb begin
        depth = 2'd0;
        if (state_q == RUN && bus.id_valid) begin
            if (bus.id_is_cbz && cbz_ex_match && bus.ex_is_load) begin
                depth = 2'(LOAD_CBZ_DEPTH);
            end else if ((bus.id_is_cbz && cbz_ex_match && !bus.ex_is_load) ||
                         (bus.id_is_cbz && cbz_mem_match && bus.mem_is_load) ||
                         (bus.id_is_bcond && bus.ex_sets_flags) ||
                         (bus.ex_is_load && ((bus.id_uses_rn && rn_ex_match) ||
                                             (bus.id_uses_rm && rm_ex_match)))) begin
                depth = 2'(ALU_CBZ_DEPTH);
            end
        end
    end

    // Every stall cycle except the final STALL1 release.
    always_comb begin
        stalling = ((state_q == RUN) && (depth != 2'd0)) || (state_q == STALL2);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; an external stall freezes the sequencer.
    always_comb begin
        state_d = state_q;
        if (!bus.ext_stall) begin
            unique case (state_q)
                RUN: begin
                    if (depth == 2'(LOAD_CBZ_DEPTH)) begin
                        state_d = STALL2;
                    end else if (depth == 2'(ALU_CBZ_DEPTH)) begin
                        state_d = STALL1;
                    end
                end
                STALL2:  state_d = STALL1;
                STALL1:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Pipeline controls: reset forces a bubble/flush, ext_stall freezes all.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (!reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (bus.ext_stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
        end else if (stalling) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            // A branch seen while stalling is re-resolved after release.
            ifid_flush  = bus.id_br_taken;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.idex_bubble = idex_bubble;
    assign bus.ifid_flush  = ifid_flush;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Count bubble and flush cycles outside reset; wraps naturally.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, idex_bubble};
        flush_count_d  = flush_count_q + {31'd0, ifid_flush};
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives decode/EX/MEM state, pushes
// the expected controls and counter values, then pops and compares them
// mid-cycle against the DUT.
module tb_hazard_ctrl;

    logic clk;
    logic reset;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pc_we;
        logic        ifid_we;
        logic        bubble;
        logic        flush;
        logic [31:0] stalls;
        logic [31:0] flushes;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic [31:0] mdl_stalls;
    logic [31:0] mdl_flushes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.id_valid      = 1'b0;
        bus.id_is_cbz     = 1'b0;
        bus.id_is_bcond   = 1'b0;
        bus.id_uses_rn    = 1'b0;
        bus.id_uses_rm    = 1'b0;
        bus.id_rn         = 5'd0;
        bus.id_rm         = 5'd0;
        bus.id_rt         = 5'd0;
        bus.id_br_taken   = 1'b0;
        bus.ex_wr_en      = 1'b0;
        bus.ex_is_load    = 1'b0;
        bus.ex_sets_flags = 1'b0;
        bus.ex_rd         = 5'd0;
        bus.mem_wr_en     = 1'b0;
        bus.mem_is_load   = 1'b0;
        bus.mem_rd        = 5'd0;
        bus.ext_stall     = 1'b0;
    endtask

    // CBZ Xrt in decode with LDUR Xrt in EX.
    task automatic set_ld_cbz(input logic [4:0] r, input logic taken);
        clear_in();
        bus.id_valid    = 1'b1;
        bus.id_is_cbz   = 1'b1;
        bus.id_rt       = r;
        bus.id_br_taken = taken;
        bus.ex_wr_en    = 1'b1;
        bus.ex_is_load  = 1'b1;
        bus.ex_rd       = r;
    endtask

    // One clock: push expectation, compare mid-cycle, advance past the edge.
    task automatic step(input string tag, input logic pc, input logic ifid,
                        input logic bub, input logic fl);
        exp_t e;
        e.tag     = tag;
        e.pc_we   = pc;
        e.ifid_we = ifid;
        e.bubble  = bub;
        e.flush   = fl;
`ifdef HAZARD_PERF_EN
        e.stalls  = mdl_stalls;
        e.flushes = mdl_flushes;
`else
        e.stalls  = 32'd0;
        e.flushes = 32'd0;
`endif
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check({e.tag, ".pc_we"}, {31'd0, bus.pc_we}, {31'd0, e.pc_we});
        check({e.tag, ".ifid_we"}, {31'd0, bus.ifid_we}, {31'd0, e.ifid_we});
        check({e.tag, ".idex_bubble"}, {31'd0, bus.idex_bubble}, {31'd0, e.bubble});
        check({e.tag, ".ifid_flush"}, {31'd0, bus.ifid_flush}, {31'd0, e.flush});
        check({e.tag, ".stall_cycles"}, bus.stall_cycles, e.stalls);
        check({e.tag, ".flush_count"}, bus.flush_count, e.flushes);
        if (reset) begin
            mdl_stalls  = mdl_stalls + {31'd0, bub};
            mdl_flushes = mdl_flushes + {31'd0, fl};
        end else begin
            mdl_stalls  = 32'd0;
            mdl_flushes = 32'd0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        mdl_stalls  = 32'd0;
        mdl_flushes = 32'd0;
        reset       = 1'b0;
        clear_in();
        @(posedge clk);
        #1;

        // Reset forces bubble + flush, counters cleared by the first edge.
        step("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        step("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // CBZ X3 behind LDUR X3: two bubbles then release.
        set_ld_cbz(5'd3, 1'b0);
        step("ldcbz_run", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ex_wr_en = 1'b0;
        bus.ex_is_load = 1'b0;
        step("ldcbz_s2", 1'b0, 1'b0, 1'b1, 1'b0);
        step("ldcbz_s1", 1'b1, 1'b1, 1'b0, 1'b0);
        clear_in();
        step("ldcbz_after", 1'b1, 1'b1, 1'b0, 1'b0);

        // CBZ X5 behind ADD X5: one bubble.
        clear_in();
        bus.id_valid  = 1'b1;
        bus.id_is_cbz = 1'b1;
        bus.id_rt     = 5'd5;
        bus.ex_wr_en  = 1'b1;
        bus.ex_rd     = 5'd5;
        step("alucbz_run", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ex_wr_en = 1'b0;
        step("alucbz_s1", 1'b1, 1'b1, 1'b0, 1'b0);
        // Same with XZR: never a hazard.
        bus.id_rt    = 5'd31;
        bus.ex_rd    = 5'd31;
        bus.ex_wr_en = 1'b1;
        step("alucbz_xzr", 1'b1, 1'b1, 1'b0, 1'b0);
        bus.ex_is_load = 1'b1;
        step("ldcbz_xzr", 1'b1, 1'b1, 1'b0, 1'b0);

        // ADD X1,X2,X7 behind LDUR X7 in EX: one bubble.
        clear_in();
        bus.id_valid   = 1'b1;
        bus.id_uses_rn = 1'b1;
        bus.id_uses_rm = 1'b1;
        bus.id_rn      = 5'd2;
        bus.id_rm      = 5'd7;
        bus.ex_wr_en   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd7;
        step("loaduse_run", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ex_wr_en = 1'b0;
        step("loaduse_s1", 1'b1, 1'b1, 1'b0, 1'b0);
        // LDUR X7 in MEM instead: forwarded, no stall.
        bus.ex_is_load  = 1'b0;
        bus.mem_wr_en   = 1'b1;
        bus.mem_is_load = 1'b1;
        bus.mem_rd      = 5'd7;
        step("loaduse_mem", 1'b1, 1'b1, 1'b0, 1'b0);

        // CBZ behind LDUR in MEM: one bubble.
        clear_in();
        bus.id_valid    = 1'b1;
        bus.id_is_cbz   = 1'b1;
        bus.id_rt       = 5'd9;
        bus.mem_wr_en   = 1'b1;
        bus.mem_is_load = 1'b1;
        bus.mem_rd      = 5'd9;
        step("memcbz_run", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.mem_wr_en = 1'b0;
        step("memcbz_s1", 1'b1, 1'b1, 1'b0, 1'b0);

        // B.cond behind a flag setter: one bubble.
        clear_in();
        bus.id_valid      = 1'b1;
        bus.id_is_bcond   = 1'b1;
        bus.ex_sets_flags = 1'b1;
        step("bcond_run", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ex_sets_flags = 1'b0;
        step("bcond_s1", 1'b1, 1'b1, 1'b0, 1'b0);

        // Taken CBZ, no hazard: single flush.
        clear_in();
        bus.id_valid    = 1'b1;
        bus.id_is_cbz   = 1'b1;
        bus.id_rt       = 5'd4;
        bus.id_br_taken = 1'b1;
        step("br_flush", 1'b1, 1'b1, 1'b0, 1'b1);
        clear_in();
        step("br_after", 1'b1, 1'b1, 1'b0, 1'b0);

        // Taken CBZ behind LDUR: flush held until the release cycle.
        set_ld_cbz(5'd6, 1'b1);
        step("brld_run", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ex_wr_en = 1'b0;
        step("brld_s2", 1'b0, 1'b0, 1'b1, 1'b0);
        step("brld_s1", 1'b1, 1'b1, 1'b0, 1'b1);
        clear_in();
        step("brld_after", 1'b1, 1'b1, 1'b0, 1'b0);

        // ext_stall for 3 cycles in STALL2: everything frozen.
        set_ld_cbz(5'd8, 1'b0);
        step("ext_run", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ex_wr_en    = 1'b0;
        bus.ext_stall   = 1'b1;
        bus.id_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("ext_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus.ext_stall   = 1'b0;
        bus.id_br_taken = 1'b0;
        step("ext_s2", 1'b0, 1'b0, 1'b1, 1'b0);
        step("ext_s1", 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset mid-stall abandons it.
        set_ld_cbz(5'd10, 1'b0);
        step("rstmid_run", 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step("rstmid_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        clear_in();
        bus.id_valid = 1'b1;
        bus.id_rn    = 5'd1;
        step("rstmid_free", 1'b1, 1'b1, 1'b0, 1'b0);
        step("rstmid_free2", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
